// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and constants for the 2-to-1 stream mux
//
// Contents:
//   state_t   arbitration FSM state (idle, or locked to one source mid-packet)
//   SRC0/SRC1 source identifiers, as carried on grant and out_sel

package stream_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/stream_mux_2to1_if.sv
// rtl/stream_mux_2to1_if.sv - handshake bundle for the 2-to-1 stream mux
//
// Signals:
//   in0_valid/in0_data/in0_last/in0_ready  source 0 stream
//   in1_valid/in1_data/in1_last/in1_ready  source 1 stream
//   out_valid/out_data/out_last/out_sel    merged output stream, out_sel = source
//   out_ready                              sink acceptance
// Modports:
//   master  the mux itself (drives source readies and the merged output)
//   slave   the surroundings (sources and sink)

interface stream_mux_2to1_if #(
  parameter int WIDTH = 8
);

  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;

  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;
  logic             out_ready;

  modport master (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_sel,
    input  out_ready
  );

  modport slave (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_sel,
    output out_ready
  );

endinterface

// File: rtl/rr_arb_2.sv
// rtl/rr_arb_2.sv - combinational two-way round-robin arbiter with packet lock
//
// Ports:
//   req0, req1   source requests (source valid)
//   ptr          preferred source when both request in idle
//   state        current FSM state; a lock state pins the grant
//   grant        granted source (SRC0/SRC1)
//   grant_valid  a grant exists this cycle

module rr_arb_2
  import stream_mux_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  logic   ptr,
  input  state_t state,
  output logic   grant,
  output logic   grant_valid
);

  always_comb begin
    grant       = SRC0;
    grant_valid = 1'b0;
    unique case (state)
      // A lock holds the grant even across valid gaps of the owning source,
      // so the other source can never slip a beat into the packet.
      ST_LOCK0: begin
        grant       = SRC0;
        grant_valid = 1'b1;
      end
      ST_LOCK1: begin
        grant       = SRC1;
        grant_valid = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          grant       = ptr;
          grant_valid = 1'b1;
        end else if (req0) begin
          grant       = SRC0;
          grant_valid = 1'b1;
        end else if (req1) begin
          grant       = SRC1;
          grant_valid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/stream_mux_2to1.sv
// rtl/stream_mux_2to1.sv - merges two valid/ready streams onto one registered output
//
// Ports:
//   clk    clock, all state updates on rising edge
//   rst_n  asynchronous active-low reset
//   bus    stream bundle (master modport): two source streams in, one merged
//          stream out with out_sel naming the source of each beat
// Behaviour:
//   Round-robin between sources; once a beat without last is accepted the
//   grant stays with that source until its last beat. One output register
//   stage, 1 cycle latency, full throughput while out_ready stays high.

module stream_mux_2to1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_mux_2to1_if.master  bus
);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;

  logic             grant;
  logic             grant_valid;
  logic             load;
  logic             accept;

  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             out_sel_q;

  rr_arb_2 u_arb (
    .req0        (bus.in0_valid),
    .req1        (bus.in1_valid),
    .ptr         (ptr_q),
    .state       (state_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // The output register can take a new beat when empty or being drained.
  // This makes out_ready combinationally visible on the source readies.
  assign load = ~out_valid_q | bus.out_ready;

  always_comb begin
    if (grant == SRC1) begin
      sel_valid = bus.in1_valid;
      sel_data  = bus.in1_data;
      sel_last  = bus.in1_last;
    end else begin
      sel_valid = bus.in0_valid;
      sel_data  = bus.in0_data;
      sel_last  = bus.in0_last;
    end
  end

  assign accept = grant_valid & load & sel_valid;

  // rst_n gates the readies so no source sees a handshake while in reset.
  assign bus.in0_ready = rst_n & load & grant_valid & (grant == SRC0);
  assign bus.in1_ready = rst_n & load & grant_valid & (grant == SRC1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= SRC0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (sel_last) begin
        // Packet done: release the lock and favour the other source next.
        state_d = ST_IDLE;
        ptr_d   = ~grant;
      end else begin
        state_d = (grant == SRC1) ? ST_LOCK1 : ST_LOCK0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= SRC0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      out_sel_q   <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_2to1.sv
// tb/tb_stream_mux_2to1.sv - self-checking bench for stream_mux_2to1

module tb_stream_mux_2to1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stream_mux_2to1_if #(.WIDTH(8)) bus ();

  stream_mux_2to1 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic s, input logic l);
    chk1({tag, "_valid"}, bus.out_valid, v);
    if (v) begin
      chk8({tag, "_data"}, bus.out_data, d);
      chk1({tag, "_sel"}, bus.out_sel, s);
      chk1({tag, "_last"}, bus.out_last, l);
    end
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic l);
    bus.in0_valid = v;
    bus.in0_data  = d;
    bus.in0_last  = l;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic l);
    bus.in1_valid = v;
    bus.in1_data  = d;
    bus.in1_last  = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive0(1'b0, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: the sink-visible beat, which source owns an open
  // packet (-1 = none) and which source wins the next tie.
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last;
  bit       m_sel;
  int       m_owner;
  int       m_next;

  initial begin
    m_valid = 0; m_data = 0; m_last = 0; m_sel = 0; m_owner = -1; m_next = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 0; m_data = 0; m_last = 0; m_sel = 0; m_owner = -1; m_next = 0;
        chk1("m_rst_valid", bus.out_valid, 1'b0);
        chk8("m_rst_data", bus.out_data, 8'h00);
        chk1("m_rst_sel", bus.out_sel, 1'b0);
        chk1("m_rst_last", bus.out_last, 1'b0);
        chk1("m_rst_rdy0", bus.in0_ready, 1'b0);
        chk1("m_rst_rdy1", bus.in1_ready, 1'b0);
      end else begin
        bit req [2];
        bit [7:0] dat [2];
        bit lst [2];
        bit can_take;
        int win;
        req[0] = bus.in0_valid; req[1] = bus.in1_valid;
        dat[0] = bus.in0_data;  dat[1] = bus.in1_data;
        lst[0] = bus.in0_last;  lst[1] = bus.in1_last;
        can_take = !m_valid || bus.out_ready;
        if (m_owner >= 0)            win = m_owner;
        else if (req[0] && req[1])   win = m_next;
        else if (req[0])             win = 0;
        else if (req[1])             win = 1;
        else                         win = -1;
        chk1("m_rdy0", bus.in0_ready, can_take && win == 0);
        chk1("m_rdy1", bus.in1_ready, can_take && win == 1);
        chk1("m_valid", bus.out_valid, m_valid);
        if (m_valid) begin
          chk8("m_data", bus.out_data, m_data);
          chk1("m_sel", bus.out_sel, m_sel);
          chk1("m_last", bus.out_last, m_last);
        end
        if (win >= 0 && can_take && req[win]) begin
          m_valid = 1;
          m_data  = dat[win];
          m_last  = lst[win];
          m_sel   = (win == 1);
          if (lst[win]) begin
            m_owner = -1;
            m_next  = 1 - win;
          end else begin
            m_owner = win;
          end
        end else if (bus.out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h0, h1;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive0(1'b0, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    expect_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk8("rst_data", bus.out_data, 8'h00);

    // Async reset with a beat held, then source 1 alone after release.
    bus.out_ready = 1'b1;
    drive0(1'b1, 8'h99, 1'b1);
    tick();
    expect_out("t1_pre", 1'b1, 8'h99, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    drive0(1'b1, 8'h12, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t1_async_valid", bus.out_valid, 1'b0);
    chk8("t1_async_data", bus.out_data, 8'h00);
    chk1("t1_async_sel", bus.out_sel, 1'b0);
    chk1("t1_async_last", bus.out_last, 1'b0);
    chk1("t1_async_rdy0", bus.in0_ready, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drive1(1'b1, 8'h5A, 1'b1);
    tick();
    expect_out("t1_5a", 1'b1, 8'h5A, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    expect_out("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Single source streaming.
    drive0(1'b1, 8'h11, 1'b0);
    tick();
    expect_out("t2_11", 1'b1, 8'h11, 1'b0, 1'b0);
    drive0(1'b1, 8'h22, 1'b1);
    tick();
    expect_out("t2_22", 1'b1, 8'h22, 1'b0, 1'b1);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    expect_out("t2_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Contention with single-beat packets from reset.
    do_reset();
    drive0(1'b1, 8'hA0, 1'b1);
    drive1(1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("t3_beat%0d", i), 1'b1, (i % 2) ? 8'hB0 : 8'hA0,
                 (i % 2) ? 1'b1 : 1'b0, 1'b1);
    end
    drive0(1'b0, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 1'b0);
    tick();

    // Packet lock with a mid-packet valid gap.
    drive0(1'b1, 8'h01, 1'b0);
    drive1(1'b1, 8'hFF, 1'b1);
    #1;
    chk1("t4_rdy0_first", bus.in0_ready, 1'b1);
    chk1("t4_rdy1_a", bus.in1_ready, 1'b0);
    tick();
    expect_out("t4_01", 1'b1, 8'h01, 1'b0, 1'b0);
    drive0(1'b1, 8'h02, 1'b0);
    #1;
    chk1("t4_rdy1_b", bus.in1_ready, 1'b0);
    tick();
    expect_out("t4_02", 1'b1, 8'h02, 1'b0, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    #1;
    chk1("t4_rdy1_gap", bus.in1_ready, 1'b0);
    tick();
    expect_out("t4_gap", 1'b0, 8'h00, 1'b0, 1'b0);
    drive0(1'b1, 8'h03, 1'b1);
    #1;
    chk1("t4_rdy1_c", bus.in1_ready, 1'b0);
    tick();
    expect_out("t4_03", 1'b1, 8'h03, 1'b0, 1'b1);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    expect_out("t4_ff", 1'b1, 8'hFF, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();

    // Backpressure.
    drive0(1'b1, 8'h33, 1'b1);
    tick();
    expect_out("t5_33", 1'b1, 8'h33, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    drive0(1'b1, 8'h44, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("t5_bp_rdy0_%0d", i), bus.in0_ready, 1'b0);
      chk1($sformatf("t5_bp_rdy1_%0d", i), bus.in1_ready, 1'b0);
      tick();
      expect_out($sformatf("t5_hold%0d", i), 1'b1, 8'h33, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    expect_out("t5_44", 1'b1, 8'h44, 1'b0, 1'b1);
    drive0(1'b1, 8'h55, 1'b1);
    tick();
    expect_out("t5_55", 1'b1, 8'h55, 1'b0, 1'b1);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    expect_out("t5_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-packet drops the lock.
    drive0(1'b1, 8'h66, 1'b0);
    tick();
    expect_out("t6_66", 1'b1, 8'h66, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive0(1'b0, 8'h00, 1'b0);
    #1;
    chk1("t6_rst_valid", bus.out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    drive1(1'b1, 8'h77, 1'b1);
    #1;
    chk1("t6_rdy1_after", bus.in1_ready, 1'b1);
    tick();
    expect_out("t6_77", 1'b1, 8'h77, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    // Leave ptr at source 1 and lock source 0, then reset: ptr must return to 0.
    drive0(1'b1, 8'h67, 1'b1);
    tick();
    drive0(1'b1, 8'h68, 1'b0);
    tick();
    expect_out("t6_68", 1'b1, 8'h68, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    drive0(1'b1, 8'h69, 1'b1);
    drive1(1'b1, 8'h78, 1'b1);
    #1;
    chk1("t6_ptr_rdy0", bus.in0_ready, 1'b1);
    chk1("t6_ptr_rdy1", bus.in1_ready, 1'b0);
    tick();
    expect_out("t6_69", 1'b1, 8'h69, 1'b0, 1'b1);
    tick();
    expect_out("t6_78", 1'b1, 8'h78, 1'b1, 1'b1);
    drive0(1'b0, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 1'b0);
    tick();

    // Randomized traffic; sources hold their beat until it is taken.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      h0 = bus.in0_valid && !bus.in0_ready;
      h1 = bus.in1_valid && !bus.in1_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        drive0(1'b0, 8'h00, 1'b0);
        drive1(1'b0, 8'h00, 1'b0);
        continue;
      end
      if (!h0) drive0($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      if (!h1) drive1($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_2to1.md
Name: stream_mux_2to1

Overview:
- Merges two valid/ready source streams onto one sink stream; the upstream counterpart of the 1-to-2 stream demultiplexer.
- Round-robin arbitration between sources, with grant locked for the full duration of a multi-beat packet.
- A registered output stage reports which source each beat came from on OUT_SEL.
- Sits in front of a shared consumer, e.g. a shared bus or a single-port sink fed by two producers.

Parameters:
WIDTH, 8, data bits per beat on each input and on the output.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
IN0_VALID  input  1  source 0 beat valid
IN0_DATA  input  WIDTH  source 0 beat data
IN0_LAST  input  1  source 0 beat ends packet
IN0_READY  output  1  source 0 beat accepted this cycle (when IN0_VALID)
IN1_VALID  input  1  source 1 beat valid
IN1_DATA  input  WIDTH  source 1 beat data
IN1_LAST  input  1  source 1 beat ends packet
IN1_READY  output  1  source 1 beat accepted this cycle (when IN1_VALID)
OUT_VALID  output  1  output register holds a beat
OUT_DATA  output  WIDTH  output beat data
OUT_LAST  output  1  output beat ends packet
OUT_SEL  output  1  source of output beat: 0 = IN0, 1 = IN1
OUT_READY  input  1  sink accepts output beat

Behaviour:
- Reset:
  - One clock domain (CLK). RST_N is asynchronous and active-low.
  - While RST_N = 0: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SEL=0, state=IDLE, priority pointer PTR=0.
  - While RST_N = 0, IN0_READY and IN1_READY are forced to 0.
- Handshake:
  - A beat transfers on any port in a cycle where VALID and READY are both 1.
  - Outputs are held stable while OUT_VALID=1 and OUT_READY=0.
- Output stage:
  - LOAD = ~OUT_VALID | OUT_READY.
  - INx_READY = LOAD & (GRANT == x). Combinational path from OUT_READY to INx_READY is intended.
  - When a source beat is accepted, OUT_DATA, OUT_LAST, OUT_SEL and OUT_VALID=1 are registered.
  - If OUT_READY=1 and no source beat is accepted, OUT_VALID clears.
- Latency and throughput:
  - Latency is 1 cycle from input acceptance to OUT_VALID.
  - Throughput is 1 beat/cycle with OUT_READY held high.
- State machine:
  - IDLE:
    - GRANT = the only valid source.
    - If both sources are valid, GRANT = PTR.
    - If neither is valid, no grant and both READY = 0.
    - Accepted beat with LAST=0 -> LOCK0 or LOCK1, matching the source.
    - Accepted beat with LAST=1 -> stay in IDLE, PTR = ~source.
  - LOCKx:
    - GRANT = x regardless of the other source; the other source's READY = 0.
    - Accepted beat with LAST=1 -> IDLE, PTR = ~x.
    - A gap in INx_VALID keeps the lock.
- Boundary conditions:
  - Both sources valid every cycle with single-beat packets -> strict alternation 0,1,0,1 from reset.
  - Source changing DATA while VALID=1 and READY=0 is a protocol violation; no checking is required.
  - Reset mid-packet: the lock is dropped and the in-flight output beat is discarded. No recovery of the partial packet is performed.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum for state: ST_IDLE, ST_LOCK0, ST_LOCK1.
  - Constants SRC0=1'b0 and SRC1=1'b1.
- Sub-module rr_arb_2:
  - Purely combinational.
  - Inputs: two requests, PTR, lock state. Outputs: GRANT and grant-valid.
- Top-level stream_mux_2to1 contains the FSM, PTR register, output register and READY logic.

Test Plan:
1. Reset: drive RST_N=0 while OUT_VALID=1 -> all outputs 0 immediately, asynchronously. After release, IN1_VALID=1 with DATA=0x5A, LAST=1 -> OUT_VALID=1, DATA=0x5A, SEL=1 next cycle.
2. Single source streaming: IN0 sends 0x11, 0x22 (LAST) with OUT_READY=1 -> output 0x11 then 0x22 on consecutive cycles, SEL=0, OUT_LAST=1 on the second beat.
3. Contention with single-beat packets: both sources valid with LAST=1, IN0=0xA0 and IN1=0xB0, for 4 cycles -> OUT_DATA sequence A0, B0, A0, B0.
4. Packet lock: IN0 sends 0x01, 0x02, 0x03 (LAST) while IN1 holds 0xFF valid -> output 01, 02, 03, FF. IN1_READY=0 for the first 3 cycles. A one-cycle IN0_VALID gap mid-packet still yields no FF before 03.
5. Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 and OUT_DATA=0x33 -> OUT_DATA stays 0x33 and both READYs=0. On release, following beats 0x44 and 0x55 appear with no loss or duplication.
6. Reset mid-packet: IN0 in LOCK0 after 1 beat, pulse RST_N low -> state IDLE and PTR=0. After release, only IN1 valid with 0x77 -> accepted and output with SEL=1.
